matrix_accumulator: RTL and testbench

Downstream stage of the 4x4 matrix multiplier. Captures successive 512-bit product matrices (16 unsigned 32-bit elements, row-major) over a valid/ready handshake and sums them element-wise into 16 saturating accumulators for a programmable number of terms. It then drains the 16 sums serially to the next stage over a second valid/ready handshake. This gives the "multiply then accumulate" path of the parallel adder-accumulator.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/sat_acc_lane.sv | 34 +++
 rtl/matrix_accumulator.sv | 125 ++++++++++++
 tb/tb_matrix_accumulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiply/accumulate pipeline.
// Element count, matrix geometry, default element width, stage state enum.
package matrix_pkg;

    localparam int NUM_ELEMS  = 16;
    localparam int MAT_DIM    = 4;
    localparam int DEF_ELEM_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

endpackage

// File: rtl/sat_acc_lane.sv
// One saturating accumulator lane: load overwrites, add sums with clamp.
// Ports: clk, reset, load, add, din[ELEM_W], acc[ACC_W], sat (add clamps now).
module sat_acc_lane
    import matrix_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              add,
    input  logic [ELEM_W-1:0] din,
    output logic [ACC_W-1:0]  acc,
    output logic              sat
);

    logic [ACC_W:0] sum;

    // One extra bit holds the carry that signals saturation.
    assign sum = {1'b0, acc} + (ACC_W+1)'(din);
    assign sat = add & sum[ACC_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_W'(din);
        end else if (add) begin
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/matrix_accumulator.sv
// Sums successive product matrices element-wise, then drains 16 lanes serially.
// Ports: prod/prod_valid/prod_ready in, out_data/index/valid/ready/last out, overflow, busy.
module matrix_accumulator
    import matrix_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_ELEMS*ELEM_W-1:0] prod,
    input  logic                        prod_valid,
    output logic                        prod_ready,
    input  logic [CNT_W-1:0]            num_terms,
    output logic [ACC_W-1:0]            out_data,
    output logic [3:0]                  out_index,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        overflow,
    output logic                        busy
);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CNT_W-1:0]     target;
    logic [CNT_W-1:0]     nt_eff;
    logic [3:0]           idx;
    logic [ACC_W-1:0]     acc_q [NUM_ELEMS];
    logic [NUM_ELEMS-1:0] sat;

    logic accept;
    logic load;
    logic add;
    logic drain_hs;

    assign prod_ready = (state_q != DRAIN);
    assign out_valid  = (state_q == DRAIN);
    assign busy       = (state_q != IDLE);
    assign out_index  = idx;
    assign out_last   = out_valid && (idx == 4'd15);
    assign out_data   = out_valid ? acc_q[idx] : '0;

    assign accept   = prod_valid & prod_ready;
    assign load     = accept & (state_q == IDLE);
    assign add      = accept & (state_q == ACCUM);
    assign drain_hs = out_valid & out_ready;

    // A zero term count would never terminate; treat it as a single term.
    assign nt_eff  = (num_terms == '0) ? CNT_W'(1) : num_terms;
    assign cnt_inc = cnt + CNT_W'(1);

    for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_lane
        sat_acc_lane #(
            .ELEM_W (ELEM_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .add   (add),
            .din   (prod[ELEM_W*g +: ELEM_W]),
            .acc   (acc_q[g]),
            .sat   (sat[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (prod_valid) begin
                    state_d = (nt_eff == CNT_W'(1)) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid && (cnt_inc == target)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && (idx == 4'd15)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            target   <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                cnt      <= CNT_W'(1);
                target   <= nt_eff;
                overflow <= 1'b0;
            end
            if (add) begin
                cnt      <= cnt_inc;
                overflow <= overflow | (|sat);
            end
            // idx wraps 15 -> 0 on the final handshake.
            if (drain_hs) begin
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_accumulator.sv
// Directed bench for matrix_accumulator (ACC_W=33 to reach saturation).
// Table-driven batches plus backpressure, held-valid and reset sequences.
module tb_matrix_accumulator;

    localparam int EW = 32;
    localparam int AW = 33;
    localparam int CW = 8;

    logic            clk;
    logic            reset;
    logic [16*EW-1:0] prod;
    logic            prod_valid;
    logic            prod_ready;
    logic [CW-1:0]   num_terms;
    logic [AW-1:0]   out_data;
    logic [3:0]      out_index;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            overflow;
    logic            busy;

    int checks = 0;
    int errors = 0;

    matrix_accumulator #(
        .ELEM_W (EW),
        .ACC_W  (AW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .num_terms  (num_terms),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  nt;
        int          n;
        logic [31:0] base;
        logic [31:0] step;
        logic [63:0] eb;
        logic [63:0] es;
        logic        eov;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [16*EW-1:0] pack(input logic [31:0] base,
                                              input logic [31:0] step);
        logic [16*EW-1:0] p;
        p = '0;
        for (int k = 0; k < 16; k++) begin
            p[EW*k +: EW] = base + step * k;
        end
        return p;
    endfunction

    task automatic send(input int n, input logic [7:0] nt,
                        input logic [31:0] base, input logic [31:0] step);
        prod       = pack(base, step);
        num_terms  = nt;
        prod_valid = 1'b1;
        for (int t = 0; t < n; t++) begin
            chk("prod_ready_acc", prod_ready, 1);
            tick();
            num_terms = 8'd2;
        end
        prod_valid = 1'b0;
    endtask

    task automatic drain(input logic [63:0] eb, input logic [63:0] es,
                         input logic eov);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_index", out_index, i);
            chk("drain_data", out_data, eb + es * i);
            chk("drain_last", out_last, (i == 15));
            chk("drain_prod_ready", prod_ready, 0);
            tick();
        end
        chk("post_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_prod_ready", prod_ready, 1);
        chk("post_overflow", overflow, eov);
    endtask

    initial begin
        reset      = 1'b1;
        prod       = '0;
        prod_valid = 1'b0;
        num_terms  = 8'd1;
        out_ready  = 1'b1;

        vecs[0] = '{8'd1, 1, 32'd1,   32'd1, 64'd1,   64'd1, 1'b0};
        vecs[1] = '{8'd3, 3, 32'd100, 32'd0, 64'd300, 64'd0, 1'b0};
        vecs[2] = '{8'd0, 1, 32'd5,   32'd2, 64'd5,   64'd2, 1'b0};
        vecs[3] = '{8'd2, 2, 32'hFFFF_FFFF, 32'd0,
                    64'h1_FFFF_FFFE, 64'd0, 1'b0};
        vecs[4] = '{8'd3, 3, 32'hFFFF_FFFF, 32'd0,
                    64'h1_FFFF_FFFF, 64'd0, 1'b1};
        vecs[5] = '{8'd1, 1, 32'd3,   32'd0, 64'd3,   64'd0, 1'b0};

        tick();
        tick();
        chk("rst_prod_ready", prod_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].n, vecs[v].nt, vecs[v].base, vecs[v].step);
            drain(vecs[v].eb, vecs[v].es, vecs[v].eov);
        end

        // Backpressure: ready pattern 1,0,0,1 repeating.
        begin
            int          n;
            logic        stalled;
            logic [63:0] pd;
            logic [3:0]  pi;
            n       = 0;
            stalled = 1'b0;
            pd      = '0;
            pi      = '0;
            send(1, 8'd1, 32'd1000, 32'd1);
            for (int c = 0; c < 100 && n < 16; c++) begin
                out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                chk("bp_valid", out_valid, 1);
                if (stalled) begin
                    chk("bp_hold_data", out_data, pd);
                    chk("bp_hold_index", out_index, pi);
                end
                if (out_ready) begin
                    chk("bp_index", out_index, n);
                    chk("bp_data", out_data, 1000 + n);
                    n++;
                end
                stalled = !out_ready;
                pd      = out_data;
                pi      = out_index;
                tick();
            end
            chk("bp_count", n, 16);
            chk("bp_busy_done", busy, 0);
            out_ready = 1'b1;
        end

        // prod_valid held through DRAIN becomes term 1 of the next batch.
        prod       = pack(32'd9, 32'd0);
        num_terms  = 8'd1;
        prod_valid = 1'b1;
        chk("held_ready", prod_ready, 1);
        tick();
        prod = pack(32'd20, 32'd0);
        drain(64'd9, 64'd0, 1'b0);
        tick();
        prod_valid = 1'b0;
        drain(64'd20, 64'd0, 1'b0);

        // Reset after 2 of 4 terms aborts the batch.
        send(2, 8'd4, 32'd50, 32'd0);
        chk("mid_busy", busy, 1);
        chk("mid_valid", out_valid, 0);
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_prod_ready", prod_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_index", out_index, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_overflow", overflow, 0);
        reset = 1'b0;
        tick();
        send(1, 8'd1, 32'd7, 32'd0);
        drain(64'd7, 64'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
